fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Drains the read port of the team's synchronous `fifo` block (`r_en`/`r_data`/`empty`) and presents the words as a valid/ready stream to a downstream consumer.
- Hides the FIFO's 1-cycle read latency behind a small prefetch buffer.
- Never reads an empty FIFO.
- Sustains one word per cycle when the consumer is always ready.
- Keeps a count of delivered words.

Parameters:
- DATA_WIDTH, 32, width of FIFO words and stream data.
- BUF_DEPTH, 3, prefetch buffer entries; legal minimum 2; full throughput needs at least 3.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  1 = allowed to issue new FIFO reads; 0 = pause issuing (in-flight data still delivered).
- fifo_r_en  out  1  read strobe to fifo `r_en`.
- fifo_r_data  in  DATA_WIDTH  fifo `r_data`; valid the cycle after an accepted strobe.
- fifo_empty  in  1  fifo `empty`.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream data valid.
- m_ready  in  1  consumer ready; a transfer occurs when m_valid && m_ready.
- busy  out  1  1 while a read is in flight or the buffer is non-empty.
- words_out  out  CNT_WIDTH  count of completed stream transfers.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - in-flight flag, buffer occupancy, pointers and words_out are cleared to 0.
  - m_valid=0, m_data=0, busy=0, fifo_r_en=0.
  - fifo_r_en is forced 0 while rst_n=0.
- Reset mid-operation:
  - Any in-flight read is discarded; fifo_r_data in the following cycle is ignored.
  - The buffer contents are lost.
  - The FIFO is reset by the same rst_n.
- FIFO read contract:
  - fifo_r_en sampled high with fifo_empty=0 at edge N pops one word.
  - That word appears on fifo_r_data during cycle N+1.
  - A registered inflight flag captures it at edge N+1.
- Issue rule (combinational from registered state and fifo_empty only; no path from m_ready):
  - fifo_r_en = rst_n & en & ~fifo_empty & (occ + inflight < BUF_DEPTH).
  - This guarantees no read when empty and no buffer overflow.
- Buffer:
  - Circular, BUF_DEPTH entries, wrap-around pointers.
  - A push (inflight=1) and a pop (transfer) in the same cycle leave occ unchanged.
  - Order is strictly preserved.
- Stream side:
  - m_valid = (occ != 0); m_data = head entry; both are driven from registers.
  - Once m_valid=1, m_data is held stable until the transfer.
  - m_valid never drops without a transfer, except at reset.
- Latency: strobe at edge N → m_valid=1 from cycle N+2 (empty buffer case).
- Throughput: with BUF_DEPTH≥3, en=1, FIFO non-empty and m_ready=1, the block delivers one transfer per cycle in steady state.
- en=0:
  - Stops new strobes the same cycle.
  - Already in-flight and buffered words still drain.
  - busy falls once drained.
- words_out:
  - +1 per transfer; wraps modulo 2^CNT_WIDTH.
  - Not affected by en.
- busy = inflight | (occ != 0).
- fifo_empty rising while a read is in flight: the in-flight word is still captured; no further strobes are issued.

Test Plan:
- Reset, fifo empty, en=1, m_ready=1 for 10 cycles → fifo_r_en never asserted, m_valid=0, words_out=0.
- Write 16 words 0..15 to the FIFO, then en=1, m_ready=1 → transfers carry 0..15 in order, back-to-back after a 2-cycle initial latency; words_out=16; fifo_r_en never high with fifo_empty=1.
- 16 words buffered, m_ready=0 for 20 cycles → exactly BUF_DEPTH=3 strobes; m_valid=1 with m_data=0 held stable. Then m_ready=1 → remaining 1..15 delivered, none lost or duplicated.
- m_ready toggling 1,0,1,0 with 8 words queued → 8 transfers with values 0..7; m_data stable during every m_valid&&!m_ready cycle.
- en dropped after 4 transfers → at most BUF_DEPTH additional words delivered, then m_valid=0, busy=0, no further strobes. en=1 → resumes with the next sequential value.
- rst_n=0 for one edge while 2 words are buffered and 1 is in flight → next cycle m_valid=0, busy=0, words_out=0; fifo empty; no stale word appears afterwards.
- CNT_WIDTH=4, 17 transfers → words_out=1.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - valid/ready stream bundle between fifo_stream_reader and its consumer
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a 1-cycle-latency FIFO read port into a valid/ready stream
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    input  logic                  fifo_empty,
    fifo_stream_reader_if.master  m,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_out
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
    localparam logic [OW:0]   DEPTH_W  = (OW + 1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  words_q, words_d;
    logic                  push;
    logic                  pop;
    logic                  valid_w;

    // A word returning from the FIFO always lands in the buffer; the issue
    // rule below reserves a slot for it before the strobe goes out.
    assign valid_w = (occ_q != '0);
    assign push    = inflight_q;
    assign pop     = valid_w & m.m_ready;

    // Reads are issued only from registered state and fifo_empty so the
    // consumer's ready never reaches back into the FIFO strobe.
    assign fifo_r_en = rst_n & en & ~fifo_empty &
                       (({1'b0, occ_q} + {{OW{1'b0}}, inflight_q}) < DEPTH_W);

    assign m.m_valid = valid_w;
    assign m.m_data  = buf_q[rd_ptr_q];
    assign busy      = inflight_q | valid_w;
    assign words_out = words_q;

    // Next-state for pointers, occupancy, in-flight flag and transfer counter.
    always_comb begin
        inflight_d = fifo_r_en;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        words_d    = words_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            words_d  = words_q + 1'b1;
        end
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push && pop) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // State registers and buffer storage; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            words_q    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            words_q    <= words_d;
            if (push) begin
                buf_q[wr_ptr_q] <= fifo_r_data;
            end
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;
    localparam int DW = 32;
    localparam int BD = 3;
    localparam int CW = 4;

    localparam int R_ALL    = 0;
    localparam int R_TOGGLE = 1;
    localparam int R_RAND   = 2;
    localparam int R_NONE   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          en;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_r_data;
    logic          fifo_empty;
    logic          busy;
    logic [CW-1:0] words_out;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) m_if ();

    fifo_stream_reader #(
        .DATA_WIDTH(DW),
        .BUF_DEPTH (BD),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_r_en  (fifo_r_en),
        .fifo_r_data(fifo_r_data),
        .fifo_empty (fifo_empty),
        .m          (m_if),
        .busy       (busy),
        .words_out  (words_out)
    );

    // FIFO model: 1-cycle read latency, garbage on r_data when not read.
    logic [DW-1:0] fmem [0:255];
    int unsigned   f_wr = 0;
    int unsigned   f_rd = 0;
    assign fifo_empty = (f_wr == f_rd);

    always @(posedge clk) begin
        if (!rst_n) begin
            f_rd        <= f_wr;
            fifo_r_data <= 32'hBAD0_0000;
        end else if (fifo_r_en && !fifo_empty) begin
            fifo_r_data <= fmem[f_rd[7:0]];
            f_rd        <= f_rd + 1;
        end else begin
            fifo_r_data <= 32'hBAD0_0000 | f_rd;
        end
    end

    typedef struct {
        int n_words;
        int rmode;
        int cycles;
        int exp_xfer;
        int exp_strobe;
        int exp_valid_end;
        int exp_busy_end;
    } vec_t;

    vec_t          vecs [4];
    logic [DW-1:0] exp_q [$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc_n = 0;
    int            n_strobe, n_xfer, first_strobe, first_xfer, last_xfer;
    int            rmode = R_NONE;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic [DW-1:0] next_val = '0;
    int            total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_strobe     = 0;
        n_xfer       = 0;
        first_strobe = -1;
        first_xfer   = -1;
        last_xfer    = -1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fmem[f_wr[7:0]] = next_val;
            exp_q.push_back(next_val);
            f_wr     = f_wr + 1;
            next_val = next_val + 1;
        end
    endtask

    // One clock: sample at the falling edge, then update m_ready after the rising edge.
    task automatic cyc();
        logic [DW-1:0] exp_v;
        @(negedge clk);
        cyc_n++;
        if (fifo_r_en) begin
            n_strobe++;
            if (first_strobe < 0) first_strobe = cyc_n;
            check("strobe_while_empty", 32'(fifo_empty), 32'd0);
        end
        if (!rst_n) begin
            check("r_en_low_in_reset", 32'(fifo_r_en), 32'd0);
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_held", 32'(m_if.m_valid), 32'd1);
                check("stall_data_held", m_if.m_data, stall_data);
            end
            if (m_if.m_valid && m_if.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_transfer: actual=0x%0h required=no transfer", m_if.m_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("transfer_data", m_if.m_data, exp_v);
                end
                n_xfer++;
                if (first_xfer < 0) first_xfer = cyc_n;
                last_xfer = cyc_n;
            end
            stall_prev = m_if.m_valid && !m_if.m_ready;
            stall_data = m_if.m_data;
        end
        @(posedge clk);
        #1;
        case (rmode)
            R_ALL:    m_if.m_ready = 1'b1;
            R_TOGGLE: m_if.m_ready = ~m_if.m_ready;
            R_RAND:   m_if.m_ready = ($urandom_range(0, 3) != 0);
            default:  m_if.m_ready = 1'b0;
        endcase
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) cyc();
        rst_n = 1'b1;
        exp_q.delete();
        stall_prev = 1'b0;
        total = 0;
    endtask

    initial begin
        int x0, s0, budget;
        logic [DW-1:0] first_v;

        vecs[0] = '{n_words: 16, rmode: R_ALL,    cycles: 30, exp_xfer: 16, exp_strobe: 16, exp_valid_end: 0, exp_busy_end: 0};
        vecs[1] = '{n_words: 8,  rmode: R_TOGGLE, cycles: 30, exp_xfer: 8,  exp_strobe: 8,  exp_valid_end: 0, exp_busy_end: 0};
        vecs[2] = '{n_words: 5,  rmode: R_RAND,   cycles: 40, exp_xfer: 5,  exp_strobe: 5,  exp_valid_end: 0, exp_busy_end: 0};
        vecs[3] = '{n_words: 1,  rmode: R_ALL,    cycles: 10, exp_xfer: 1,  exp_strobe: 1,  exp_valid_end: 0, exp_busy_end: 0};

        rst_n = 1'b0;
        en = 1'b0;
        m_if.m_ready = 1'b0;
        clear_stats();
        do_reset(2);

        check("rst_m_valid", 32'(m_if.m_valid), 32'd0);
        check("rst_m_data", m_if.m_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_r_en", 32'(fifo_r_en), 32'd0);
        check("rst_words_out", 32'(words_out), 32'd0);

        // Empty FIFO: nothing may be read or presented.
        en = 1'b1;
        rmode = R_ALL;
        m_if.m_ready = 1'b1;
        clear_stats();
        for (int i = 0; i < 10; i++) cyc();
        check("empty_strobes", n_strobe, 0);
        check("empty_m_valid", 32'(m_if.m_valid), 32'd0);
        check("empty_words_out", 32'(words_out), 32'd0);

        // Table-driven drain runs.
        foreach (vecs[k]) begin
            clear_stats();
            m_if.m_ready = 1'b1;
            rmode = vecs[k].rmode;
            push_words(vecs[k].n_words);
            for (int c = 0; c < vecs[k].cycles; c++) cyc();
            total += vecs[k].n_words;
            check("tbl_xfers", n_xfer, vecs[k].exp_xfer);
            check("tbl_strobes", n_strobe, vecs[k].exp_strobe);
            check("tbl_drained", exp_q.size(), 0);
            check("tbl_valid_end", 32'(m_if.m_valid), vecs[k].exp_valid_end);
            check("tbl_busy_end", 32'(busy), vecs[k].exp_busy_end);
            check("tbl_words_out", 32'(words_out), total % 16);
            if (vecs[k].rmode == R_ALL) begin
                check("tbl_latency", first_xfer - first_strobe, 2);
                check("tbl_back_to_back", last_xfer - first_xfer, vecs[k].n_words - 1);
            end
        end

        // Consumer stalled: exactly BUF_DEPTH strobes, head held, then full drain.
        clear_stats();
        rmode = R_NONE;
        m_if.m_ready = 1'b0;
        first_v = next_val;
        push_words(16);
        for (int i = 0; i < 20; i++) cyc();
        check("stall_strobes", n_strobe, BD);
        check("stall_m_valid", 32'(m_if.m_valid), 32'd1);
        check("stall_m_data", m_if.m_data, first_v);
        rmode = R_ALL;
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 30; i++) cyc();
        check("stall_xfers", n_xfer, 16);
        check("stall_drained", exp_q.size(), 0);

        // en dropped after 4 transfers, then resumed.
        clear_stats();
        push_words(16);
        budget = 0;
        while (n_xfer < 4 && budget < 60) begin
            cyc();
            budget++;
        end
        check("en_first_four", n_xfer, 4);
        en = 1'b0;
        x0 = n_xfer;
        s0 = n_strobe;
        for (int i = 0; i < 10; i++) cyc();
        check("en0_no_strobe", n_strobe, s0);
        check("en0_extra_bounded", 32'((n_xfer - x0) <= BD), 32'd1);
        check("en0_m_valid", 32'(m_if.m_valid), 32'd0);
        check("en0_busy", 32'(busy), 32'd0);
        en = 1'b1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            cyc();
            budget++;
        end
        for (int i = 0; i < 3; i++) cyc();
        check("en1_drained", exp_q.size(), 0);
        check("en1_xfers", n_xfer, 16);
        check("en1_busy", 32'(busy), 32'd0);

        // Reset with two words buffered and one in flight.
        clear_stats();
        rmode = R_NONE;
        m_if.m_ready = 1'b0;
        push_words(8);
        for (int i = 0; i < 3; i++) cyc();
        check("pre_rst_strobes", n_strobe, 3);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_valid", 32'(m_if.m_valid), 32'd1);
        do_reset(1);
        check("midrst_m_valid", 32'(m_if.m_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_words_out", 32'(words_out), 32'd0);
        check("midrst_fifo_empty", 32'(fifo_empty), 32'd1);
        rmode = R_ALL;
        m_if.m_ready = 1'b1;
        clear_stats();
        for (int i = 0; i < 10; i++) cyc();
        check("post_rst_xfers", n_xfer, 0);
        check("post_rst_strobes", n_strobe, 0);

        // Counter wrap: 17 transfers with a 4-bit counter.
        clear_stats();
        push_words(17);
        for (int i = 0; i < 40; i++) cyc();
        check("wrap_xfers", n_xfer, 17);
        check("wrap_words_out", 32'(words_out), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
